// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchronizer, bit-centre sampling, byte out with valid / framing-error pulses.
// Latency ~9.5 bit periods + 3 clocks from start edge; no backpressure. `UART_RX_MAJORITY_EN selects 2-of-3 sampling.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int CNT_W        = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    output logic [7:0] data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       bit_cnt, bit_n;
    logic [7:0]       shreg, shreg_n;
    logic [7:0]       data_n;
    logic             valid_n, err_n;
    logic             rx_m, rx_s;
    logic [CNT_W-1:0] target;
    logic             at_target;
    logic             sample;

    // Synchronizer flops reset high so a released reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= RxD;
            rx_s <= rx_m;
        end
    end

    assign target    = (state == START) ? HALF_M1 : FULL_M1;
    assign at_target = (cnt == target);

`ifdef UART_RX_MAJORITY_EN
    logic maj2, maj1;

    // Capture the two samples leading up to the decision point.
    always_ff @(posedge clk) begin
        if (reset) begin
            maj2 <= 1'b1;
            maj1 <= 1'b1;
        end else begin
            if (cnt == target - CNT_W'(2)) maj2 <= rx_s;
            if (cnt == target - CNT_W'(1)) maj1 <= rx_s;
        end
    end

    assign sample = (maj2 & maj1) | (maj2 & rx_s) | (maj1 & rx_s);
`else
    assign sample = rx_s;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            data      <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_cnt   <= bit_n;
            shreg     <= shreg_n;
            data      <= data_n;
            rx_valid  <= valid_n;
            frame_err <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        data_n  = data;
        valid_n = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (at_target) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = sample ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (at_target) begin
                    cnt_n   = '0;
                    shreg_n = {sample, shreg[7:1]};
                    bit_n   = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) state_n = STOP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                // Leave at mid-stop-bit so a start bit right after the stop bit is caught.
                if (at_target) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (sample) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       RxD;
    logic [7:0] data;
    logic       rx_valid, frame_err, busy;

    uart_receiver #(.CLKS_PER_BIT(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .RxD(RxD),
        .data(data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    int         nvalid = 0, nerr = 0, nbusy = 0, overlap = 0;
    int         vcyc[$];
    logic [7:0] vdat[$];
    logic       vbusy[$];

    always @(negedge clk) begin
        if (rx_valid) begin
            nvalid++;
            vcyc.push_back(cyc);
            vdat.push_back(data);
            vbusy.push_back(busy);
        end
        if (frame_err) nerr++;
        if (busy) nbusy++;
        if (rx_valid && frame_err) overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        RxD = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_out(input logic v, input logic glitch);
        RxD = v;
        if (glitch) begin
            repeat (7) @(posedge clk);
            #1 RxD = ~v;
            @(posedge clk);
            #1 RxD = v;
            repeat (8) @(posedge clk);
        end else begin
            repeat (16) @(posedge clk);
        end
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input logic glitch);
        bit_out(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i], glitch);
        bit_out(stop, 1'b0);
    endtask

    function automatic logic [31:0] qdat(input int i);
        return (vdat.size() > i) ? {24'h0, vdat[i]} : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] qcyc(input int i);
        return (vcyc.size() > i) ? vcyc[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        int v0, e0, b0, c0, q;
        logic g;
`ifdef UART_RX_MAJORITY_EN
        g = 1'b1;
`else
        g = 1'b0;
`endif
        RxD   = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_data", data, 8'h00);
        chk("rst_valid", rx_valid, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;

        v0 = nvalid; e0 = nerr; b0 = nbusy;
        idle(400);
        chk("idle_valid", nvalid - v0, 0);
        chk("idle_err", nerr - e0, 0);
        chk("idle_busy", nbusy - b0, 0);

        // Single byte A5: count, value, latency, busy drop on the valid edge.
        v0 = nvalid; e0 = nerr; q = vdat.size(); c0 = cyc;
        send(8'hA5, 1'b1, 1'b0);
        idle(16);
        chk("a5_count", nvalid - v0, 1);
        chk("a5_data", qdat(q), 8'hA5);
        chk("a5_err", nerr - e0, 0);
        chk("a5_latency", qcyc(q) - c0, 155);
        chk("a5_busy", (vbusy.size() > q) ? {31'h0, vbusy[q]} : 32'hDEAD_BEEF, 0);

        // Back-to-back 00 then FF, no idle gap.
        v0 = nvalid; q = vdat.size();
        send(8'h00, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        idle(16);
        chk("b2b_count", nvalid - v0, 2);
        chk("b2b_data0", qdat(q), 8'h00);
        chk("b2b_data1", qdat(q + 1), 8'hFF);
        chk("b2b_gap", qcyc(q + 1) - qcyc(q), 160);

        // Stop bit forced low.
        v0 = nvalid; e0 = nerr;
        send(8'h3C, 1'b0, 1'b0);
        idle(40);
        chk("ferr_err", nerr - e0, 1);
        chk("ferr_valid", nvalid - v0, 0);
        chk("ferr_data", data, 8'hFF);
        chk("ferr_overlap", overlap, 0);

        // 4-clock low glitch, shorter than half a bit.
        v0 = nvalid; e0 = nerr; b0 = nbusy;
        RxD = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        idle(40);
        chk("glitch_valid", nvalid - v0, 0);
        chk("glitch_err", nerr - e0, 0);
        chk("glitch_busy_len", ((nbusy - b0) >= 1 && (nbusy - b0) <= 8) ? 1 : 0, 1);
        chk("glitch_idle", busy, 0);

        // Reset in the middle of DATA for 5A, then a clean 81.
        v0 = nvalid; e0 = nerr;
        bit_out(1'b0, 1'b0);
        bit_out(1'b0, 1'b0);
        bit_out(1'b1, 1'b0);
        RxD = 1'b0;
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        RxD = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        idle(40);
        chk("abort_valid", nvalid - v0, 0);
        chk("abort_err", nerr - e0, 0);
        chk("abort_busy", busy, 0);
        q = vdat.size();
        send(8'h81, 1'b1, g);
        idle(16);
        chk("b81_count", nvalid - v0, 1);
        chk("b81_data", qdat(q), 8'h81);
        chk("b81_err", nerr - e0, 0);
        chk("final_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage: 8N1, LSB first, idle-high line.
- Downstream peer of the 8N1 UART transmitter. Converts the incoming RxD line into bytes for the matrix-multiply operand loader.
- Same baud-timing convention as the transmit path: one bit period = CLKS_PER_BIT system clocks. Default is 100 MHz / 9600 baud.

Parameters:
- CLKS_PER_BIT, 10416, system clocks per bit period. Legal range 8..16383.
- CNT_W, 14, width of the baud counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock. All logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- RxD  input  1  asynchronous serial input. Idle level is 1.
- data  output  8  last correctly framed byte. Holds its value until the next good frame.
- rx_valid  output  1  one-cycle pulse when data has been updated.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clocking and reset:
  - The design has one clock (clk). Reset is synchronous and active-high (reset).
  - Reset values: data=8'h00, rx_valid=0, frame_err=0, busy=0, FSM=IDLE, baud counter=0, bit counter=0, shift register=0.
  - Both synchronizer flops reset to 1, so no false start is detected as reset deasserts.
  - Reset asserted mid-frame aborts the frame immediately. No pulse is produced.
- Synchronizer: RxD passes through 2 flops to form rx_s. All decisions use rx_s only. The async-to-detect latency is 2 clocks.
- FSM states, with transitions evaluated each clk:
  - IDLE: busy=0, baud counter held at 0. When rx_s==0: go to START, counter=0.
  - START: counter increments. At counter==CLKS_PER_BIT/2-1 (integer division; 5207 at default):
    - if rx_s==0, go to DATA with counter=0 and bit counter=0;
    - otherwise it is a glitch: return to IDLE with no pulse.
  - DATA: counter increments. At counter==CLKS_PER_BIT-1 (mid-bit):
    - shift register shifts right with rx_s entering bit 7;
    - bit counter increments and counter resets to 0;
    - after the 8th sample (bit counter reaches 8), go to STOP.
  - STOP: at counter==CLKS_PER_BIT-1:
    - if rx_s==1: data<=shift register and rx_valid=1 for exactly one cycle;
    - if rx_s==0: frame_err=1 for exactly one cycle and data is unchanged;
    - in both cases go to IDLE on the same edge.
- Timing:
  - Sampling happens at the centre of each bit. The return to IDLE happens at mid-stop-bit, so a back-to-back start bit that begins at the end of the stop bit is caught.
  - rx_valid and frame_err are never both high. Neither is asserted outside STOP exit.
  - Latency: rx_valid rises about 9.5 bit periods plus 3 clocks after the RxD start-bit falling edge.
- Break condition: if the line is held at 0, a frame_err pulse is followed by re-entry to START. The next frame is accepted normally once the line returns high and a proper start bit arrives.
- The baud counter never exceeds CLKS_PER_BIT-1. There is no wrap beyond that value.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Every sampling decision (start confirmation, each data bit, stop bit) uses the 2-of-3 majority of rx_s captured at target-2, target-1 and target counter values. For START the target is CLKS_PER_BIT/2-1.
  - A single-clock glitch at the sample point is therefore rejected.
  - Requires CLKS_PER_BIT >= 8.
- Undefined: a single sample of rx_s is taken at the target count. The majority registers are not built.

Test Plan (bench sets CLKS_PER_BIT=16):
- Reset held 3 cycles with RxD=1, then released → data=00, rx_valid=0, frame_err=0, busy=0. No activity over 400 cycles.
- Send 8N1 byte 8'hA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) → exactly one rx_valid pulse, data=A5 at that cycle, frame_err=0. busy falls on the same edge.
- Back-to-back 8'h00 then 8'hFF with no idle gap → two rx_valid pulses 160 clocks apart, data=00 then FF.
- Byte 8'h3C with stop bit forced 0 → one frame_err pulse, no rx_valid, data keeps its previous value.
- RxD low pulse of 4 clocks (shorter than half a bit), then idle → FSM returns to IDLE, no pulses, busy high for ≤8 clocks.
- Assert reset for 1 cycle mid-DATA of byte 8'h5A, then send 8'h81 → no pulse for 5A, rx_valid with data=81. With UART_RX_MAJORITY_EN defined, also inject a 1-clock inverted glitch at each data bit's centre of 8'h81 → still data=81.
